// File: rtl/sop_sweep_if.sv
// sop_sweep_if: valid/ready beat stream carrying {vector, f} from the sweeper to its sink.
interface sop_sweep_if #(parameter int N_IN = 3);
  logic out_valid;
  logic out_ready;
  logic out_f;
  logic [N_IN-1:0] out_vec;
  modport master(output out_valid, out_vec, out_f, input out_ready);
  modport slave(input out_valid, out_vec, out_f, output out_ready);
endinterface

// File: rtl/sop_sweep.sv
// sop_sweep: exhaustive evaluator streaming every input vector of an N_IN-input truth-table function.
// Define SOP_SWEEP_CHECK_EN to add the expected-mask comparison ports (exp_mask, mismatch, err_count).
module sop_sweep #(
  parameter int N_IN = 3,
  localparam int LUT_W = 1 << N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LUT_W-1:0] func_mask,
`ifdef SOP_SWEEP_CHECK_EN
  input  logic [LUT_W-1:0] exp_mask,
  output logic             mismatch,
  output logic [N_IN:0]    err_count,
`endif
  sop_sweep_if.master      out_if,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    ones_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [LUT_W-1:0] mask_q, mask_d;
  logic [N_IN:0] ones_q, ones_d;
  logic go, fire, last, f;
  assign go   = (state_q == IDLE) && start;
  assign fire = (state_q == RUN) && out_if.out_ready;
  assign last = idx_q == N_IN'(LUT_W - 1);
  assign f    = mask_q[idx_q];
  always_comb begin
    state_d = go ? RUN : (state_q == RUN) ? ((fire && last) ? DONE : RUN) : IDLE;
    idx_d   = go ? '0 : (fire && !last) ? idx_q + 1'b1 : idx_q;
    mask_d  = go ? func_mask : mask_q;
    ones_d  = go ? '0 : fire ? ones_q + {{N_IN{1'b0}}, f} : ones_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      ones_q  <= ones_d;
    end
  end
  assign out_if.out_valid = state_q == RUN;
  assign out_if.out_vec   = idx_q;
  assign out_if.out_f     = f;
  assign busy             = state_q != IDLE;
  assign done             = state_q == DONE;
  assign ones_count       = ones_q;
`ifdef SOP_SWEEP_CHECK_EN
  logic [LUT_W-1:0] exp_q, exp_d;
  logic [N_IN:0] err_q, err_d;
  assign mismatch = (state_q == RUN) && (f != exp_q[idx_q]);
  always_comb begin
    exp_d = go ? exp_mask : exp_q;
    err_d = go ? '0 : (fire && mismatch) ? err_q + 1'b1 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      err_q <= '0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end
  assign err_count = err_q;
`endif
endmodule
